// File: rtl/load_store_unit.sv
// load_store_unit: rv32i load/store sequencer with alignment checks, byte lanes and timeout
module load_store_unit #(
  parameter int ADDR_W  = 12,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [31:0]       addr,
  input  logic [31:0]       rs2_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              req,
  output logic              wr_en,
  output logic [3:0]        mask,
  output logic [31:0]       w_data,
  input  logic [31:0]       r_data,
  input  logic              valid,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       load_data
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t state, state_n;
  logic          st_q;
  logic [2:0]    f3_q;
  logic [1:0]    lo_q;
  logic [CW-1:0] cnt;
  logic          ill, mis, bad, hit, err_n;
  logic [3:0]    mask_n;
  logic [31:0]   wdata_n, byte_sh, half_sh, ld_n;
  logic          unused_addr;
  assign unused_addr = ^addr[31:ADDR_W+2];
  always_comb begin
    ill = funct3 == 3'b011 || funct3[2:1] == 2'b11 || (is_store && funct3 >= 3'b011);
    mis = (funct3[1:0] == 2'b01 && addr[0]) || (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
    bad = ill || mis;
    hit = cnt == CW'(TIMEOUT - 1);
    err_n = state == IDLE ? bad : !valid;
    state_n = state;
    case (state)
      IDLE: state_n = start ? (bad ? DONE : REQ) : IDLE;
      REQ:  state_n = WAIT;
      WAIT: state_n = (valid || hit) ? DONE : WAIT;
      DONE: state_n = IDLE;
    endcase
    mask_n = funct3[1:0] == 2'b00 ? 4'b0001 << addr[1:0] :
             funct3[1:0] == 2'b01 ? 4'b0011 << {addr[1], 1'b0} : 4'b1111;
    wdata_n = funct3[1:0] == 2'b00 ? {4{rs2_data[7:0]}} :
              funct3[1:0] == 2'b01 ? {2{rs2_data[15:0]}} : rs2_data;
    byte_sh = r_data >> {lo_q, 3'b000};
    half_sh = r_data >> {lo_q[1], 4'b0000};
    ld_n = f3_q[1:0] == 2'b00 ? {{24{!f3_q[2] && byte_sh[7]}}, byte_sh[7:0]} :
           f3_q[1:0] == 2'b01 ? {{16{!f3_q[2] && half_sh[15]}}, half_sh[15:0]} : r_data;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      st_q      <= 1'b0;
      f3_q      <= '0;
      lo_q      <= '0;
      cnt       <= '0;
      mem_addr  <= '0;
      req       <= 1'b0;
      wr_en     <= 1'b0;
      mask      <= '0;
      w_data    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      load_data <= '0;
    end else begin
      state <= state_n;
      req   <= state_n == REQ;
      wr_en <= state == IDLE && state_n == REQ && is_store;
      busy  <= state_n != IDLE;
      done  <= state_n == DONE;
      err   <= state_n == DONE && err_n;
      cnt   <= state == WAIT ? cnt + CW'(1) : '0;
      if (state == IDLE && start) begin
        st_q     <= is_store;
        f3_q     <= funct3;
        lo_q     <= addr[1:0];
        mem_addr <= addr[ADDR_W+1:2];
        mask     <= mask_n;
        w_data   <= wdata_n;
      end
      if (state == WAIT && valid && !st_q) load_data <= ld_n;
    end
  end
endmodule
